vector_proc_core: RTL

VECTOR_PROC_CORE -- requirements
Module: vector_proc_core

---
 rtl/vproc_pkg.sv | 35 +++
 rtl/vproc_mem.sv | 29 ++
 rtl/vector_proc_core.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vproc_pkg.sv
// Shared definitions for the vector processor core.
// Holds the opcode encoding, the FSM state type and helpers that derive
// instruction field widths from the core parameters.
package vproc_pkg;

  typedef enum logic [2:0] {
    OpLoad  = 3'b000,
    OpStore = 3'b001,
    OpAdd   = 3'b010,
    OpSub   = 3'b011,
    OpMul   = 3'b100,
    OpNop   = 3'b101,
    OpIll6  = 3'b110,
    OpIll7  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StMul2 = 2'b10,
    StWb   = 2'b11
  } state_e;

  // Register-index field width; at least one bit.
  function automatic int unsigned ridx_width(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  // Instruction word: {opcode[2:0], reg index, address}.
  function automatic int unsigned instr_width(input int unsigned num_regs,
                                              input int unsigned addr_w);
    return 3 + ridx_width(num_regs) + addr_w;
  endfunction

endpackage

// File: rtl/vproc_mem.sv
// Single-port data memory for the vector processor core.
// Synchronous write and one-cycle synchronous read; contents are not reset.
// Ports:
//   clock  - rising-edge clock
//   we     - write enable, mem[addr] <= wdata on the edge
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data of mem[addr] from the previous edge
module vproc_mem #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vector_proc_core.sv
// Small vector processor core: register file, signed ALU and control FSM
// around a single-port data memory.
// Ports:
//   clock        - rising-edge clock
//   reset        - synchronous active-low reset
//   instr_valid  - instruction present on instr
//   instr        - {opcode, reg index, address}
//   instr_ready  - core idle and able to accept an instruction
//   regs_out     - flattened register file, reg k at [k*DATA_W +: DATA_W]
//   busy         - instruction in flight
//   done         - one-cycle completion pulse
//   err          - pulses with done for an illegal instruction
module vector_proc_core
  import vproc_pkg::*;
#(
  parameter int unsigned  DATA_W   = 512,
  parameter int unsigned  NUM_REGS = 4,
  parameter int unsigned  ADDR_W   = 9,
  localparam int unsigned RIDX_W   = ridx_width(NUM_REGS),
  localparam int unsigned IW       = instr_width(NUM_REGS, ADDR_W)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       instr_valid,
  input  logic [IW-1:0]              instr,
  output logic                       instr_ready,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  state_e state_q, state_d;

  opcode_e           op_q;
  logic [RIDX_W-1:0] idx_q;
  logic [ADDR_W-1:0] addr_q;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [2*DATA_W-1:0] result_q;
  logic [DATA_W-1:0]   mul_a_q, mul_b_q;

  logic [2*DATA_W-1:0] r0_ext, r1_ext, mul_a_ext, mul_b_ext;
  logic                idx_ok, illegal, accept;

  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Operands are sign-extended to full result width so that plain unsigned
  // add/sub/mul on the extended values yield the correct signed results.
  assign r0_ext    = {{DATA_W{regs_q[0][DATA_W-1]}}, regs_q[0]};
  assign r1_ext    = {{DATA_W{regs_q[1][DATA_W-1]}}, regs_q[1]};
  assign mul_a_ext = {{DATA_W{mul_a_q[DATA_W-1]}}, mul_a_q};
  assign mul_b_ext = {{DATA_W{mul_b_q[DATA_W-1]}}, mul_b_q};

  // Index range only needs checking when NUM_REGS leaves unused encodings.
  if (NUM_REGS == (32'd1 << RIDX_W)) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_cmp
    assign idx_ok = ({{(32 - RIDX_W){1'b0}}, idx_q} < NUM_REGS);
  end

  always_comb begin
    illegal = 1'b0;
    case (op_q)
      OpLoad, OpStore: illegal = !idx_ok;
      OpIll6, OpIll7:  illegal = 1'b1;
      default:         illegal = 1'b0;
    endcase
  end

  assign accept = instr_valid & instr_ready;

  // Reset gates the write so a STORE aborted in EXEC leaves memory intact.
  assign mem_we = reset && (state_q == StExec) && (op_q == OpStore) && !illegal;

  vproc_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (regs_q[idx_q]),
    .rdata (mem_rdata)
  );

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = (op_q == OpMul) ? StMul2 : StWb;
      StMul2: state_d = StWb;
      StWb:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    instr_ready = (state_q == StIdle);
    busy        = (state_q != StIdle);
    done        = (state_q == StWb);
    err         = (state_q == StWb) && illegal;
  end

  // Datapath: instruction latch, ALU result and register file.
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q     <= OpLoad;
      idx_q    <= '0;
      addr_q   <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        op_q   <= opcode_e'(instr[IW-1 -: 3]);
        idx_q  <= instr[ADDR_W +: RIDX_W];
        addr_q <= instr[ADDR_W-1:0];
      end

      if (state_q == StExec) begin
        case (op_q)
          OpAdd: result_q <= r0_ext + r1_ext;
          OpSub: result_q <= r0_ext - r1_ext;
          OpMul: begin
            mul_a_q <= regs_q[0];
            mul_b_q <= regs_q[1];
          end
          default: ;
        endcase
      end

      if (state_q == StMul2) begin
        result_q <= mul_a_ext * mul_b_ext;
      end

      if (state_q == StWb && !illegal) begin
        case (op_q)
          OpLoad: regs_q[idx_q] <= mem_rdata;
          OpAdd, OpSub, OpMul: begin
            regs_q[2] <= result_q[DATA_W-1:0];
            regs_q[3] <= result_q[2*DATA_W-1:DATA_W];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_out[k*DATA_W +: DATA_W] = regs_q[k];
    end
  end

endmodule
